// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: serialises pipeline (P) and external (X) accesses over a
// fixed-latency memory. P has priority, and a streak limit keeps X from starving.
module dm_arbiter #(
  parameter int unsigned LAT    = 2,
  parameter int unsigned STREAK = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        P_Req,
  input  logic        P_Wr,
  input  logic [31:0] P_Addr,
  input  logic [31:0] P_WD,
  input  logic [2:0]  P_Op,
  output logic        P_Stall,
  output logic        P_Done,
  output logic [31:0] P_RD,
  input  logic        X_Req,
  input  logic        X_Wr,
  input  logic [31:0] X_Addr,
  input  logic [31:0] X_WD,
  input  logic [2:0]  X_Op,
  output logic        X_Done,
  output logic [31:0] X_RD,
  output logic        Mem_En,
  output logic        Mem_Wr,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WD,
  output logic [2:0]  Mem_Op,
  input  logic [31:0] Mem_RD,
  output logic [1:0]  Dbg_State
);

  // Handshake: a requester raises Req with stable fields and holds them until its
  // one-cycle Done pulse; Req is only sampled in IDLE, so a rise during DONE waits a cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_C    = 4'(LAT);
  localparam logic [3:0] STREAK_C = 4'(STREAK);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 1 = X owns the current access
  logic [3:0]  streak_q, streak_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] p_rd_q, p_rd_d;
  logic [31:0] x_rd_q, x_rd_d;
  logic        grant_x;

  assign grant_x = X_Req & (~P_Req | (streak_q >= STREAK_C));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      streak_q <= 4'd0;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      addr_q   <= 32'd0;
      wd_q     <= 32'd0;
      op_q     <= 3'd0;
      p_rd_q   <= 32'd0;
      x_rd_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      op_q     <= op_d;
      p_rd_q   <= p_rd_d;
      x_rd_q   <= x_rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    op_d     = op_q;
    p_rd_d   = p_rd_q;
    x_rd_d   = x_rd_q;
    case (state_q)
      S_IDLE: begin
        if (P_Req | X_Req) begin
          state_d = S_ISSUE;
          owner_d = grant_x;
          if (grant_x) begin
            wr_d     = X_Wr;
            addr_d   = X_Addr;
            wd_d     = X_WD;
            op_d     = X_Op;
            streak_d = 4'd0;
          end else begin
            wr_d     = P_Wr;
            addr_d   = P_Addr;
            wd_d     = P_WD;
            op_d     = P_Op;
            // Count only P grants that made a waiting X lose
            if (!X_Req)                    streak_d = 4'd0;
            else if (streak_q >= STREAK_C) streak_d = STREAK_C;
            else                           streak_d = streak_q + 4'd1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_C;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          if (!wr_q) begin
            if (owner_q) x_rd_d = Mem_RD;
            else         p_rd_d = Mem_RD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Mem_En = (state_q == S_ISSUE);
    Mem_Wr = (state_q == S_ISSUE) & wr_q;
    P_Done = (state_q == S_DONE) & ~owner_q;
    X_Done = (state_q == S_DONE) & owner_q;
  end

  assign P_Stall   = P_Req & ~P_Done;
  assign P_RD      = p_rd_q;
  assign X_RD      = x_rd_q;
  assign Mem_Addr  = addr_q;
  assign Mem_WD    = wd_q;
  assign Mem_Op    = op_q;
  assign Dbg_State = state_q;

endmodule
